// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM states,
// register offsets inside the 16-byte window and STATUS bit layout.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam logic [31:0] REG_TXDATA = 32'h0000_0000;
    localparam logic [31:0] REG_STATUS = 32'h0000_0004;
    localparam logic [31:0] WINDOW_SIZE = 32'd16;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;
    localparam int STAT_CNT_W   = 4;

    function automatic logic [31:0] pack_status(
        input logic                  busy,
        input logic                  full,
        input logic                  empty,
        input logic                  ovf,
        input logic [STAT_CNT_W-1:0] cnt
    );
        logic [31:0] s;
        s                             = '0;
        s[STAT_BUSY]                  = busy;
        s[STAT_FULL]                  = full;
        s[STAT_EMPTY]                 = empty;
        s[STAT_OVF]                   = ovf;
        s[STAT_CNT_LSB +: STAT_CNT_W] = cnt;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read. A push while full is
// accepted only when a pop happens on the same edge.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem[rd_ptr_q];

    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA pushes bytes into a FIFO that a
// start/data/stop FSM drains onto tx, STATUS reports FIFO and FSM state.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_8000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] ADR,
    input  logic [31:0] WriteData,
    output logic [31:0] RdData,
    output logic        Sel,
    output logic        tx
);

    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int BIT_CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(CLKS_PER_BIT - 1);

    logic [31:0]          offset;
    logic                 wr_en;
    logic                 push;
    logic                 pop;
    logic                 ovf_clr;
    logic                 ovf_evt;
    logic                 overflow_q, overflow_d;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;
    logic [7:0]           fifo_rd_data;
    logic [31:0]          status;
    logic                 unused_wdata;

    tx_state_e            state_q;
    logic [BIT_CNT_W-1:0] bit_cnt_q;
    logic [2:0]           bit_idx_q;
    logic [7:0]           shift_q;
    logic                 tx_q;
    logic                 bit_end;

    // Unsigned wrap makes addresses below the base fall outside the window.
    assign offset = ADR - BASE_ADDR;
    assign Sel    = (offset < WINDOW_SIZE);

    assign wr_en   = reset && MemWrite && Sel;
    assign push    = wr_en && (offset == REG_TXDATA);
    assign ovf_clr = wr_en && (offset == REG_STATUS) && WriteData[STAT_OVF];
    assign ovf_evt = push && fifo_full && !pop;

    assign unused_wdata = ^WriteData[31:8];

    assign bit_end = (bit_cnt_q == BIT_LAST);
    assign pop     = !fifo_empty &&
                     ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end));

    sync_fifo #(
        .DATA_W (8),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push    (push),
        .wr_data (WriteData[7:0]),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // A drop on the same edge as a clear leaves the flag set.
    always_comb begin
        overflow_d = overflow_q;
        if (ovf_clr) begin
            overflow_d = 1'b0;
        end
        if (ovf_evt) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            tx_q      <= 1'b1;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
        end else begin
            bit_cnt_q <= ((state_q == ST_IDLE) || bit_end) ? '0 : bit_cnt_q + 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        state_q <= ST_START;
                        tx_q    <= 1'b0;
                        shift_q <= fifo_rd_data;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state_q   <= ST_DATA;
                        bit_idx_q <= '0;
                        tx_q      <= shift_q[0];
                        shift_q   <= {1'b0, shift_q[7:1]};
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= ST_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            tx_q    <= shift_q[0];
                            shift_q <= {1'b0, shift_q[7:1]};
                        end
                    end
                end
                ST_STOP: begin
                    // Chain straight into the next start bit when data is queued.
                    if (bit_end) begin
                        if (pop) begin
                            state_q <= ST_START;
                            tx_q    <= 1'b0;
                            shift_q <= fifo_rd_data;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign tx = tx_q;

    assign status = pack_status(state_q != ST_IDLE, fifo_full, fifo_empty,
                                overflow_q, STAT_CNT_W'(fifo_count));

    always_comb begin
        RdData = '0;
        if (Sel && (offset == REG_STATUS)) begin
            RdData = status;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4: reset, single frame,
// FIFO overflow, back-to-back frames, mid-frame reset and address decode.
module tb_mmio_uart_tx;

    localparam int          CPB  = 4;
    localparam logic [31:0] BASE = 32'h0000_8000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] ADR = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] RdData;
    logic        Sel;
    logic        tx;

    int checks = 0;
    int failures = 0;

    mmio_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .ADR       (ADR),
        .WriteData (WriteData),
        .RdData    (RdData),
        .Sel       (Sel),
        .tx        (tx)
    );

    always #5 clk = ~clk;

    // Serial line receiver: samples mid-bit on falling edges.
    int         cyc = 0;
    bit         mon_busy = 1'b0;
    int         mon_k = 0;
    int         mon_start = 0;
    int         framing_err = 0;
    logic [7:0] mon_byte = '0;
    logic [7:0] rx_q [$];
    int         rx_start_q [$];

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                mon_busy = 1'b0;
            end else begin
                if (!mon_busy && !tx) begin
                    mon_busy  = 1'b1;
                    mon_k     = 0;
                    mon_start = cyc;
                    mon_byte  = '0;
                end
                if (mon_busy) begin
                    if ((mon_k % CPB) == (CPB / 2)) begin
                        if ((mon_k / CPB) == 0) begin
                            if (tx) framing_err++;
                        end else if ((mon_k / CPB) <= 8) begin
                            mon_byte[(mon_k / CPB) - 1] = tx;
                        end else if (!tx) begin
                            framing_err++;
                        end
                    end
                    if (mon_k == 10 * CPB - 1) begin
                        mon_busy = 1'b0;
                        rx_q.push_back(mon_byte);
                        rx_start_q.push_back(mon_start);
                    end
                    mon_k++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        ADR       = a;
        WriteData = d;
        tick();
        MemWrite  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic s);
        ADR = a;
        #1;
        d = RdData;
        s = Sel;
    endtask

    logic [31:0] rdata;
    logic        rsel;
    logic [9:0]  pat;
    int          lowcnt;
    int          w;

    initial begin
        // Reset held two cycles with a TXDATA write pending
        reset     = 1'b0;
        MemWrite  = 1'b1;
        ADR       = BASE;
        WriteData = 32'h33;
        tick();
        tick();
        MemWrite = 1'b0;
        check_eq("rst_tx", 32'(tx), 32'd1);
        rd(BASE + 32'd4, rdata, rsel);
        check_eq("rst_status", rdata, 32'h0000_0004);
        check_eq("rst_sel_in", 32'(rsel), 32'd1);
        rd(BASE + 32'd16, rdata, rsel);
        check_eq("rst_sel_out", 32'(rsel), 32'd0);
        check_eq("rst_rd_out", rdata, 32'd0);
        reset = 1'b1;
        tick();
        tick();
        rd(BASE + 32'd4, rdata, rsel);
        check_eq("rst_wr_ignored", rdata, 32'h0000_0004);
        check_eq("rst_tx_idle", 32'(tx), 32'd1);
        rd(BASE, rdata, rsel);
        check_eq("txdata_reads0", rdata, 32'd0);

        // Single frame 0xA5, upper write bits ignored
        rx_q.delete();
        rx_start_q.delete();
        wr(BASE, 32'hFFFF_FFA5);
        check_eq("frame_pre_tx", 32'(tx), 32'd1);
        pat = {1'b1, 8'hA5, 1'b0};
        for (int j = 0; j < 10 * CPB; j++) begin
            tick();
            check_eq($sformatf("frame_cyc%0d", j), 32'(tx), 32'(pat[j / CPB]));
        end
        tick();
        rd(BASE + 32'd4, rdata, rsel);
        check_eq("frame_status_idle", rdata, 32'h0000_0004);
        check_eq("frame_rx_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) check_eq("frame_rx_byte", 32'(rx_q[0]), 32'hA5);

        // Ten writes in consecutive cycles overflow the 8-entry FIFO
        rx_q.delete();
        rx_start_q.delete();
        for (int i = 0; i < 10; i++) begin
            MemWrite  = 1'b1;
            ADR       = BASE;
            WriteData = 32'(i);
            tick();
        end
        MemWrite = 1'b0;
        rd(BASE + 32'd4, rdata, rsel);
        check_eq("ovf_status", rdata, 32'h0000_008B);
        wr(BASE + 32'd4, 32'h8);
        rd(BASE + 32'd4, rdata, rsel);
        check_eq("ovf_clr_bit3", 32'(rdata[3]), 32'd0);
        check_eq("ovf_after_clr", rdata, 32'h0000_0083);
        w = 0;
        while (rx_q.size() < 9 && w < 600) begin
            tick();
            w++;
        end
        repeat (60) tick();
        check_eq("ovf_nframes", 32'(rx_q.size()), 32'd9);
        for (int i = 0; i < 9; i++) begin
            if (i < rx_q.size()) check_eq($sformatf("ovf_byte%0d", i), 32'(rx_q[i]), 32'(i));
        end
        rd(BASE + 32'd4, rdata, rsel);
        check_eq("ovf_drained", rdata, 32'h0000_0004);

        // Back-to-back frames with no idle gap
        rx_q.delete();
        rx_start_q.delete();
        MemWrite  = 1'b1;
        ADR       = BASE;
        WriteData = 32'h55;
        tick();
        WriteData = 32'h0F;
        tick();
        MemWrite = 1'b0;
        w = 0;
        while (rx_q.size() < 2 && w < 200) begin
            tick();
            w++;
        end
        tick();
        check_eq("b2b_nframes", 32'(rx_q.size()), 32'd2);
        if (rx_q.size() >= 2) begin
            check_eq("b2b_byte0", 32'(rx_q[0]), 32'h55);
            check_eq("b2b_byte1", 32'(rx_q[1]), 32'h0F);
            check_eq("b2b_gap", 32'(rx_start_q[1] - rx_start_q[0]), 32'(10 * CPB));
        end
        check_eq("b2b_framing", 32'(framing_err), 32'd0);
        rd(BASE + 32'd4, rdata, rsel);
        check_eq("b2b_status_idle", rdata, 32'h0000_0004);

        // Reset asserted during data bit 3 of a 0xFF frame
        rx_q.delete();
        rx_start_q.delete();
        wr(BASE, 32'hFF);
        w = 0;
        while (tx && w < 10) begin
            tick();
            w++;
        end
        check_eq("mfr_start_bit", 32'(tx), 32'd0);
        repeat (16) tick();
        rd(BASE + 32'd4, rdata, rsel);
        check_eq("mfr_busy", rdata, 32'h0000_0005);
        check_eq("mfr_data_bit", 32'(tx), 32'd1);
        reset = 1'b0;
        tick();
        check_eq("mfr_tx", 32'(tx), 32'd1);
        rd(BASE + 32'd4, rdata, rsel);
        check_eq("mfr_status", rdata, 32'h0000_0004);
        reset  = 1'b1;
        lowcnt = 0;
        for (int j = 0; j < 50; j++) begin
            tick();
            if (!tx) lowcnt++;
        end
        check_eq("mfr_no_restart", 32'(lowcnt), 32'd0);
        check_eq("mfr_no_frame", 32'(rx_q.size()), 32'd0);

        // Writes outside TXDATA or without MemWrite must not start a frame
        wr(BASE + 32'd16, 32'h41);
        wr(BASE + 32'd8, 32'h41);
        MemWrite  = 1'b0;
        ADR       = BASE;
        WriteData = 32'h41;
        tick();
        lowcnt = 0;
        for (int j = 0; j < 20; j++) begin
            tick();
            if (!tx) lowcnt++;
        end
        check_eq("dec_tx_idle", 32'(lowcnt), 32'd0);
        rd(BASE + 32'd4, rdata, rsel);
        check_eq("dec_status", rdata, 32'h0000_0004);
        rd(BASE + 32'd8, rdata, rsel);
        check_eq("dec_rd8", rdata, 32'd0);
        check_eq("dec_sel8", 32'(rsel), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
